// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, a constant clog2 and the
// default gap/watchdog lengths used by the UART tops.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int UART_GAP_TICKS = 16;
    localparam int UART_TMO_TICKS = 4096;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit after 'last',
// wrapping modulo NREQ.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        req,
    input  logic [clog2(NREQ)-1:0] last,
    output logic [clog2(NREQ)-1:0] winner,
    output logic                   valid
);

    localparam int OW = clog2(NREQ);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last) + i) % NREQ;
            if (!valid && req[idx]) begin
                winner = OW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters,
// with a TICK-timed inter-frame gap and a watchdog on the transmitter.
//
//   state   | meaning
//   IDLE    | waiting for any request; grants and starts on the same edge
//   SEND    | frame in flight, watchdog counting TICKs until TX_DONE
//   GAP     | idle line enforced for GAP_TICKS TICKs before the next grant
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DBIT      = 8,
    parameter int GAP_TICKS = UART_GAP_TICKS,
    parameter int TMO_TICKS = UART_TMO_TICKS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DBIT-1:0]   data_in,
    input  logic                   tick,
    input  logic                   tx_done,
    output logic [NREQ-1:0]        grant,
    output logic                   tx_start,
    output logic [DBIT-1:0]        tx_data,
    output logic [clog2(NREQ)-1:0] owner,
    output logic                   busy,
    output logic                   tmo_err
);

    localparam int OW   = clog2(NREQ);
    localparam int CMAX = (GAP_TICKS > TMO_TICKS) ? GAP_TICKS : TMO_TICKS;
    localparam int CW   = (clog2(CMAX + 1) < 1) ? 1 : clog2(CMAX + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_TICKS - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_TICKS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t          state, state_nxt;
    logic [CW-1:0]   wd_cnt, wd_nxt;
    logic [CW-1:0]   gap_cnt, gap_nxt;
    logic [OW-1:0]   last, last_nxt;
    logic [OW-1:0]   pick;
    logic            pick_valid;
    logic            send_end;
    logic [NREQ-1:0] grant_nxt;
    logic            tx_start_nxt;
    logic [DBIT-1:0] tx_data_nxt;
    logic [OW-1:0]   owner_nxt;
    logic            tmo_err_nxt;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req    (req),
        .last   (last),
        .winner (pick),
        .valid  (pick_valid)
    );

    always_comb begin
        state_nxt    = state;
        wd_nxt       = wd_cnt;
        gap_nxt      = gap_cnt;
        last_nxt     = last;
        grant_nxt    = '0;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        owner_nxt    = owner;
        tmo_err_nxt  = 1'b0;
        send_end     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt       = ST_SEND;
                    grant_nxt[pick] = 1'b1;
                    tx_start_nxt    = 1'b1;
                    tx_data_nxt     = data_in[int'(pick) * DBIT +: DBIT];
                    owner_nxt       = pick;
                    last_nxt        = pick;
                    wd_nxt          = '0;
                end
            end
            ST_SEND: begin
                // TX_DONE takes priority over a watchdog expiry in the same cycle
                if (tx_done) begin
                    send_end = 1'b1;
                end else if (tick) begin
                    if (wd_cnt != '1) begin
                        wd_nxt = wd_cnt + 1'b1;
                    end
                    if (wd_cnt == TMO_LAST) begin
                        send_end    = 1'b1;
                        tmo_err_nxt = 1'b1;
                    end
                end
                if (send_end) begin
                    gap_nxt   = GAP_LOAD;
                    state_nxt = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_cnt == CNT_ONE || gap_cnt == '0) begin
                        gap_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        gap_nxt = gap_cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wd_cnt   <= '0;
            gap_cnt  <= '0;
            last     <= OW'(NREQ - 1);
            grant    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wd_cnt   <= wd_nxt;
            gap_cnt  <= gap_nxt;
            last     <= last_nxt;
            grant    <= grant_nxt;
            tx_start <= tx_start_nxt;
            tx_data  <= tx_data_nxt;
            owner    <= owner_nxt;
            busy     <= (state_nxt != ST_IDLE);
            tmo_err  <= tmo_err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scenario bench for uart_tx_arbiter (GAP_TICKS=16, TMO_TICKS=8): expected
// grants are queued when requests are driven and checked when TX_START fires.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [1:0] owner;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data_in;
    logic        tick = 1'b0;
    logic        tx_done = 1'b0;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  owner;
    logic        busy;
    logic        tmo_err;

    int   n_checks = 0;
    int   n_fail = 0;
    int   tmo_count = 0;
    logic prev_busy = 1'b0;
    exp_t sb[$];
    exp_t e;

    uart_tx_arbiter #(
        .NREQ(4), .DBIT(8), .GAP_TICKS(16), .TMO_TICKS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .tick(tick),
        .tx_done(tx_done), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
        .owner(owner), .busy(busy), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_of(input int i);
        case (i)
            0: return 8'h5A;
            1: return 8'h96;
            2: return 8'hA5;
            default: return 8'h3C;
        endcase
    endfunction

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_start: owner=%0d grant=%b, no grant expected", owner, grant);
            end else begin
                e = sb.pop_front();
                if (owner !== e.owner || tx_data !== e.data || grant !== (4'b0001 << e.owner)) begin
                    n_fail++;
                    $display("FAIL sb_grant: owner=%0d data=%h grant=%b expected owner=%0d data=%h grant=%b",
                             owner, tx_data, grant, e.owner, e.data, 4'b0001 << e.owner);
                end
            end
            n_checks++;
            if (prev_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL start_while_busy: prev busy=%b expected 0", prev_busy);
            end
        end else if (grant !== 4'b0000) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_without_start: grant=%b expected 0000", grant);
        end
        if (tmo_err === 1'b1) tmo_count++;
        prev_busy = busy;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_pulse();
        repeat (15) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic expect_grant(input int idx);
        sb.push_back('{owner: 2'(idx), data: byte_of(idx)});
    endtask

    task automatic finish_frame();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (16) tick_pulse();
    endtask

    task automatic test_reset();
        step();
        step();
        n_checks++;
        if (grant !== 4'b0 || tx_start !== 1'b0 || tmo_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: grant=%b tx_start=%b tmo_err=%b expected all 0", grant, tx_start, tmo_err);
        end
        n_checks++;
        if (tx_data !== 8'h00 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_regs: tx_data=%h owner=%0d expected 00 and 0", tx_data, owner);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: busy=%b expected 0", busy);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL release_idle: busy=%b tx_start=%b expected 0 0", busy, tx_start);
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        expect_grant(2);
        step();
        req = 4'b0000;
        n_checks++;
        if (grant !== 4'b0100 || tx_start !== 1'b1 || tx_data !== 8'hA5 || owner !== 2'd2) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b start=%b data=%h owner=%0d expected 0100 1 a5 2",
                     grant, tx_start, tx_data, owner);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_rise: busy=%b expected 1", busy);
        end
        step();
        n_checks++;
        if (grant !== 4'b0 || tx_start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pulse_width: grant=%b start=%b busy=%b expected 0000 0 1", grant, tx_start, busy);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick_pulse();
            if (k == 15) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_gap15: busy=%b expected 1", busy);
                end
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_gap16: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] seen;
        seen = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            expect_grant(i % 4);
            step();
            n_checks++;
            if (tx_start !== 1'b1 || owner !== 2'(i % 4)) begin
                n_fail++;
                $display("FAIL fair_order_%0d: start=%b owner=%0d expected 1 %0d", i, tx_start, owner, i % 4);
            end
            if (i < 4) begin
                n_checks++;
                if (seen[owner] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fair_repeat_%0d: owner=%0d granted twice, seen=%b", i, owner, seen);
                end
                seen[owner] = 1'b1;
            end
            finish_frame();
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_gap();
        req = 4'b0010;
        expect_grant(1);
        step();
        req = 4'b0000;
        n_checks++;
        if (tx_start !== 1'b1 || owner !== 2'd1) begin
            n_fail++;
            $display("FAIL gap_first_grant: start=%b owner=%0d expected 1 1", tx_start, owner);
        end
        tx_done = 1'b1;
        tick = 1'b1;
        step();
        tx_done = 1'b0;
        tick = 1'b0;
        req = 4'b1000;
        expect_grant(3);
        for (int k = 1; k <= 16; k++) begin
            tick_pulse();
            if (k == 15) begin
                n_checks++;
                if (busy !== 1'b1 || tx_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap_entry_tick: busy=%b start=%b after 15 ticks expected 1 0", busy, tx_start);
                end
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_end: busy=%b expected 0", busy);
        end
        step();
        req = 4'b0000;
        n_checks++;
        if (tx_start !== 1'b1 || owner !== 2'd3) begin
            n_fail++;
            $display("FAIL gap_pending_grant: start=%b owner=%0d expected 1 3", tx_start, owner);
        end
        finish_frame();
    endtask

    task automatic test_watchdog();
        int tmo_before;
        tmo_before = tmo_count;
        req = 4'b0001;
        expect_grant(0);
        step();
        req = 4'b0000;
        repeat (7) tick_pulse();
        n_checks++;
        if (tmo_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_early: tmo_err=%b busy=%b after 7 ticks expected 0 1", tmo_err, busy);
        end
        tick_pulse();
        n_checks++;
        if (tmo_err !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_fire: tmo_err=%b busy=%b after 8 ticks expected 1 1", tmo_err, busy);
        end
        step();
        n_checks++;
        if (tmo_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_pulse_width: tmo_err=%b expected 0", tmo_err);
        end
        repeat (15) tick_pulse();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_gap15: busy=%b expected 1", busy);
        end
        tick_pulse();
        n_checks++;
        if (busy !== 1'b0 || tmo_count !== tmo_before + 1) begin
            n_fail++;
            $display("FAIL wd_gap_end: busy=%b tmo pulses=%0d expected 0 and %0d", busy, tmo_count, tmo_before + 1);
        end
    endtask

    task automatic test_done_at_terminal();
        int tmo_before;
        tmo_before = tmo_count;
        req = 4'b0010;
        expect_grant(1);
        step();
        req = 4'b0000;
        repeat (7) tick_pulse();
        repeat (15) step();
        tick = 1'b1;
        tx_done = 1'b1;
        step();
        tick = 1'b0;
        tx_done = 1'b0;
        n_checks++;
        if (tmo_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL term_done_wins: tmo_err=%b busy=%b expected 0 1", tmo_err, busy);
        end
        repeat (16) tick_pulse();
        n_checks++;
        if (busy !== 1'b0 || tmo_count !== tmo_before) begin
            n_fail++;
            $display("FAIL term_no_tmo: busy=%b tmo pulses=%0d expected 0 and %0d", busy, tmo_count, tmo_before);
        end
    endtask

    task automatic test_reset_mid_send();
        req = 4'b0100;
        expect_grant(2);
        step();
        req = 4'b0000;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (grant !== 4'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 || owner !== 2'd0 ||
            busy !== 1'b0 || tmo_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: grant=%b start=%b data=%h owner=%0d busy=%b tmo=%b expected all 0",
                     grant, tx_start, tx_data, owner, busy, tmo_err);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_start: start=%b busy=%b expected 0 0", tx_start, busy);
        end
        req = 4'b1001;
        expect_grant(0);
        step();
        req = 4'b0000;
        n_checks++;
        if (tx_start !== 1'b1 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_grant: start=%b owner=%0d expected 1 0", tx_start, owner);
        end
        finish_frame();
    endtask

    task automatic test_stray();
        logic [3:0] pats [4];
        pats = '{4'b1111, 4'b0000, 4'b1010, 4'b0110};
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_done_idle: busy=%b start=%b expected 0 0", busy, tx_start);
        end
        req = 4'b0001;
        expect_grant(0);
        step();
        for (int k = 0; k < 4; k++) begin
            req = pats[k];
            step();
            n_checks++;
            if (grant !== 4'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stray_req_send_%0d: grant=%b busy=%b expected 0000 1", k, grant, busy);
            end
        end
        req = 4'b0000;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (3) tick_pulse();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_done_gap: busy=%b expected 1", busy);
        end
        repeat (12) tick_pulse();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_gap15: busy=%b expected 1", busy);
        end
        tick_pulse();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_gap16: busy=%b expected 0", busy);
        end
    endtask

    initial begin
        data_in = {byte_of(3), byte_of(2), byte_of(1), byte_of(0)};
        test_reset();
        test_single();
        test_fairness();
        test_gap();
        test_watchdog();
        test_done_at_terminal();
        test_reset_mid_send();
        test_stray();
        step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d grants never seen, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
